// File: rtl/receptor_pkg.sv
// Shared UART definitions: frame width, oversampling factor and one-hot receiver states.
// Imported by the receiver and its synchronizer.
package receptor_pkg;

    localparam int NBITS_DEF     = 8;
    localparam int NUM_TICKS_DEF = 16;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE  = 4'b0001;
    localparam state_t ST_START = 4'b0010;
    localparam state_t ST_DATA  = 4'b0100;
    localparam state_t ST_STOP  = 4'b1000;

    // Width of the data-bit index; never zero even for a one-bit frame.
    function automatic int nbits_w(input int nbits);
        return (nbits > 1) ? $clog2(nbits) : 1;
    endfunction

endpackage

// File: rtl/receptor_sincronizador.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones so an idle-high line
// never looks like a start bit coming out of reset.
module sincronizador #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/receptor.sv
// UART receiver, 8N1, oversampled by NUM_TICKS: deserializes LSB-first frames from rx,
// pulses rx_done_tick for one clk with data_out/frame_error updated on the same edge.
module receptor
    import receptor_pkg::*;
#(
    parameter int NBITS     = NBITS_DEF,
    parameter int NUM_TICKS = NUM_TICKS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             rx,
    output logic [NBITS-1:0] data_out,
    output logic             rx_done_tick,
    output logic             frame_error
);

    localparam int ACC_W = $clog2(NUM_TICKS);
    localparam int N_W   = nbits_w(NBITS);

    localparam logic [ACC_W-1:0] ACC_MID  = ACC_W'(NUM_TICKS / 2 - 1);
    localparam logic [ACC_W-1:0] ACC_LAST = ACC_W'(NUM_TICKS - 1);
    localparam logic [N_W-1:0]   N_LAST   = N_W'(NBITS - 1);

    logic rx_s;

    sincronizador #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [NBITS-1:0] buf_q, buf_d;
    logic [NBITS-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            n_q     <= '0;
            buf_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            buf_q   <= buf_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        n_d     = n_q;
        buf_d   = buf_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = ferr_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    acc_d   = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (acc_q == ACC_MID) begin
                        // A start bit that is high again by mid-bit is a glitch.
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                        acc_d   = '0;
                        n_d     = '0;
                    end else begin
                        acc_d = acc_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (acc_q == ACC_LAST) begin
                        buf_d = {rx_s, buf_q[NBITS-1:1]};
                        acc_d = '0;
                        if (n_q == N_LAST) begin
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        acc_d = acc_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (acc_q == ACC_LAST) begin
                        data_d  = buf_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                        acc_d   = '0;
                    end else begin
                        acc_d = acc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                acc_d   = '0;
                n_d     = '0;
            end
        endcase
    end

    always_comb begin
        data_out     = data_q;
        rx_done_tick = done_q;
        frame_error  = ferr_q;
    end

endmodule

// File: tb/tb_receptor.sv
// Randomized scoreboard bench for the UART receiver: a behavioural transmitter drives rx
// and queues the expected word; an independent monitor checks every done pulse.
`timescale 1ns/1ps
module tb_receptor;

    localparam int NB = 8;
    localparam int NT = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          tick = 1'b0;
    logic          rx = 1'b1;
    logic [NB-1:0] data_out;
    logic          rx_done_tick;
    logic          frame_error;

    receptor #(.NBITS(NB), .NUM_TICKS(NT)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .rx           (rx),
        .data_out     (data_out),
        .rx_done_tick (rx_done_tick),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int expected_frames = 0;
    int tick_div = 1;
    int tick_cnt = 0;

    typedef struct packed {
        logic [NB-1:0] dat;
        logic          ferr;
    } exp_t;

    exp_t exp_q[$];

    // Tick enable: one clk high every tick_div clks, changed away from the sampling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (tick_cnt >= tick_div - 1) begin
                tick     = 1'b1;
                tick_cnt = 0;
            end else begin
                tick     = 1'b0;
                tick_cnt = tick_cnt + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests = tests + 1;
        if (act !== req) begin
            fails = fails + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding frame.
    always @(negedge clk) begin
        if (!reset && rx_done_tick === 1'b1) begin
            exp_t e;
            pulses = pulses + 1;
            if (exp_q.size() == 0) begin
                tests = tests + 1;
                fails = fails + 1;
                $display("FAIL unexpected_pulse: data_out %0h frame_error %0b, no frame pending",
                         data_out, frame_error);
            end else begin
                e = exp_q.pop_front();
                check("data_out", 32'(data_out), 32'(e.dat));
                check("frame_error", 32'(frame_error), 32'(e.ferr));
            end
        end
    end

    task automatic hold_ticks(input int n);
        int cnt = 0;
        while (cnt < n) begin
            @(posedge clk);
            if (tick) cnt = cnt + 1;
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx = b;
        hold_ticks(NT);
    endtask

    task automatic send_frame(input logic [NB-1:0] d, input logic stop_val);
        exp_t e;
        e.dat  = d;
        e.ferr = ~stop_val;
        exp_q.push_back(e);
        expected_frames = expected_frames + 1;
        send_bit(1'b0);
        for (int i = 0; i < NB; i++) send_bit(d[i]);
        send_bit(stop_val);
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk);
        rx = 1'b1;
        hold_ticks(n * NT);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #990000;
        $display("FAIL watchdog: simulation time limit reached, %0d frames outstanding", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB-1:0] b;
        int            wait_cnt;

        do_reset(3);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_done", 32'(rx_done_tick), 32'h0);
        check("reset_frame_error", 32'(frame_error), 32'h0);
        idle_bits(1);

        send_frame(8'hA5, 1'b1);
        idle_bits(2);

        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(2);

        // Short low pulse on rx must be rejected as a glitch.
        @(negedge clk);
        rx = 1'b0;
        hold_ticks(4);
        idle_bits(3);
        check("glitch_keeps_data", 32'(data_out), 32'hFF);
        check("glitch_no_pulse", 32'(pulses), 32'(expected_frames));

        send_frame(8'h3C, 1'b0);
        idle_bits(2);
        send_frame(8'h11, 1'b1);
        idle_bits(2);

        // Abort 0x5A by a reset during data bit 4; no pulse may come from it.
        b = 8'h5A;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        @(negedge clk);
        rx = b[4];
        hold_ticks(NT / 2);
        do_reset(2);
        rx = 1'b1;
        check("midframe_reset_data", 32'(data_out), 32'h0);
        check("midframe_reset_ferr", 32'(frame_error), 32'h0);
        idle_bits(12);
        check("aborted_no_pulse", 32'(pulses), 32'(expected_frames));
        send_frame(8'h81, 1'b1);
        idle_bits(2);

        // Random byte stream with small random idle gaps, tick every clk.
        for (int k = 0; k < 240; k++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1);
            if ($urandom_range(0, 1) == 1) idle_bits($urandom_range(1, 2));
        end
        idle_bits(2);

        // Slow baud: tick every 27 clks.
        tick_div = 27;
        idle_bits(1);
        for (int k = 0; k < 6; k++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1);
        end
        idle_bits(1);

        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 20000) begin
            @(posedge clk);
            wait_cnt = wait_cnt + 1;
        end
        check("outstanding_frames", 32'(exp_q.size()), 32'h0);
        check("pulse_count", 32'(pulses), 32'(expected_frames));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
